// File: rtl/mul_seq_pkg.sv
// Shared constants, state encoding and bit-vector helpers for the one-hot
// shift-and-add multiply sequencer.
package mul_seq_pkg;

  localparam int WIDTH = 32;
  localparam int IDXW  = 5;
  localparam int CNTW  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Positions whose binary index has bit k set; feeds one OR-tree per index bit.
  function automatic logic [WIDTH-1:0] idx_mask(input int k);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = 1'(i >> k);
    end
    return m;
  endfunction

  // Ripple "seen a bit below" chain; any set bit above a seen bit is a second one.
  function automatic logic at_most_one_hot(input logic [WIDTH-1:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      multi = multi | (v[i] & seen);
      seen  = seen | v[i];
    end
    return ~multi;
  endfunction

endpackage

// File: rtl/onehot_index_32.sv
// Combinational one-hot to binary index encoder built as one OR-tree per
// index bit; an all-zero input encodes to index 0.
module onehot_index_32
  import mul_seq_pkg::*;
(
  input  logic [WIDTH-1:0] onehot,
  output logic [IDXW-1:0]  idx
);

  for (genvar k = 0; k < IDXW; k++) begin : g_idx_bit
    assign idx[k] = |(onehot & idx_mask(k));
  end

endmodule

// File: rtl/onehot_mul_seq_32.sv
// Multi-cycle unsigned 32x32 multiplier: one partial product per set bit of
// the multiplier, lowest bit first, accumulated into a 64-bit register.
module onehot_mul_seq_32
  import mul_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 single_hot,
  output logic [CNTW-1:0]      run_cycles
);

  state_t                state_r;
  state_t                next_state_s;
  logic [2*WIDTH-1:0]    mcand_r;
  logic [WIDTH-1:0]      mplier_r;
  logic [2*WIDTH-1:0]    acc_r;
  logic [CNTW-1:0]       count_r;
  logic [2*WIDTH-1:0]    product_r;
  logic [CNTW-1:0]       run_cycles_r;
  logic                  single_hot_r;
  logic                  busy_r;
  logic                  done_r;

  logic [WIDTH-1:0]      low_s;
  logic [WIDTH-1:0]      rest_s;
  logic [IDXW-1:0]       idx_s;
  logic [2*WIDTH-1:0]    addend_s;
  logic [2*WIDTH-1:0]    acc_next_s;
  logic [CNTW-1:0]       count_next_s;

  assign low_s        = mplier_r & (~mplier_r + 32'd1);
  assign rest_s       = mplier_r ^ low_s;
  assign addend_s     = mcand_r << idx_s;
  assign count_next_s = count_r + 6'd1;

  onehot_index_32 u_index (
    .onehot (low_s),
    .idx    (idx_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and the accumulate step of a RUN cycle.
  always_comb begin
    next_state_s = state_r;
    acc_next_s   = acc_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // A zero multiplier still spends one RUN cycle but adds nothing.
        if (mplier_r != 32'd0) begin
          acc_next_s = acc_r + addend_s;
        end else begin
          acc_next_s = acc_r;
        end
        if (rest_s == 32'd0) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Operand capture, accumulation and registered result/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r      <= 64'd0;
      mplier_r     <= 32'd0;
      acc_r        <= 64'd0;
      count_r      <= 6'd0;
      product_r    <= 64'd0;
      run_cycles_r <= 6'd0;
      single_hot_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      busy_r <= (next_state_s != ST_IDLE);
      done_r <= (next_state_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            mcand_r      <= {32'd0, a};
            mplier_r     <= b;
            acc_r        <= 64'd0;
            count_r      <= 6'd0;
            single_hot_r <= at_most_one_hot(b);
          end
        end
        ST_RUN: begin
          acc_r    <= acc_next_s;
          mplier_r <= rest_s;
          count_r  <= count_next_s;
          if (next_state_s == ST_DONE) begin
            product_r    <= acc_next_s;
            run_cycles_r <= count_next_s;
          end
        end
        ST_DONE: begin
          acc_r <= acc_r;
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign product    = product_r;
  assign single_hot = single_hot_r;
  assign run_cycles = run_cycles_r;

endmodule

// File: tb/tb_onehot_mul_seq_32.sv
// Directed self-checking bench for onehot_mul_seq_32 with hand-computed
// products, latencies and control-hazard cases.
module tb_onehot_mul_seq_32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic        single_hot;
  logic [5:0]  run_cycles;

  int tests  = 0;
  int failed = 0;

  onehot_mul_seq_32 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .single_hot (single_hot),
    .run_cycles (run_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it to its done pulse; pulse_at > 0 fires a
  // spurious start in that RUN cycle, and operands are scrambled after accept.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] exp_p, input logic exp_s, input int n,
                        input int pulse_at);
    int lat;
    lat = 0;
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = ~av;
    b     = ~bv;
    check({tag, "_busy_run"}, 64'(busy), 64'd1);
    check({tag, "_done_low_run"}, 64'(done), 64'd0);
    for (int c = 1; c <= 40; c++) begin
      start = (c == pulse_at);
      a     = $urandom;
      b     = $urandom;
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(n));
    check({tag, "_product"}, product, exp_p);
    check({tag, "_single_hot"}, 64'(single_hot), 64'(exp_s));
    check({tag, "_run_cycles"}, 64'(run_cycles), 64'(n));
    check({tag, "_busy_done"}, 64'(busy), 64'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_busy_idle"}, 64'(busy), 64'd0);
    check({tag, "_product_hold"}, product, exp_p);
  endtask

  initial begin
    logic seen_done;
    rst   = 1'b1;
    start = 1'b1;
    a     = 32'd1;
    b     = 32'd1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", product, 64'd0);
    check("rst_run_cycles", 64'(run_cycles), 64'd0);
    check("rst_single_hot", 64'(single_hot), 64'd0);
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_done", 64'(done), 64'd0);

    run_op("zero_b",   32'd7,          32'd0,          64'd0,                  1'b1, 1,  0);
    run_op("one_hot",  32'h0000_1234,  32'h0000_0010,  64'h0000_0000_0001_2340, 1'b1, 1,  0);
    run_op("two_bits", 32'd3,          32'h8000_0001,  64'h0000_0001_8000_0003, 1'b0, 2,  0);
    run_op("worst",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 1'b0, 32, 0);
    run_op("mid_start", 32'd6,         32'h0000_0107,  64'h0000_0000_0000_062A, 1'b0, 4,  2);

    @(negedge clk);
    start = 1'b1;
    a     = 32'd5;
    b     = 32'h0000_000F;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", product, 64'd0);
    check("abort_run_cycles", 64'(run_cycles), 64'd0);
    check("abort_single_hot", 64'(single_hot), 64'd0);
    seen_done = 1'b0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);

    run_op("after_abort", 32'd5, 32'h0000_000F, 64'h0000_0000_0000_004B, 1'b0, 4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
